self_sync_scrambler_p: RTL and testbench

SELF_SYNC_SCRAMBLER_P -- requirements
Module: self_sync_scrambler_p

---
 rtl/self_sync_scrambler_p.sv | 124 ++++++++++++
 tb/tb_self_sync_scrambler_p.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/self_sync_scrambler_p.sv
// Self-synchronising (multiplicative) scrambler/descrambler, DATA_W bits per word, LSB first.
// Latency: one cycle from accept to dout/out_valid; one word per cycle when the output drains.
// Backpressure: in_ready drops while the output register is full and not draining, or when disabled/flushing.
// Optional feature: define SCR_BYPASS_EN to add a bypass input that passes din straight through.
module self_sync_scrambler_p #(
    parameter int                DATA_W = 8,
    parameter int                LFSR_W = 7,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(7'b1100000),
    parameter logic [LFSR_W-1:0] SEED   = '0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              enable,
    input  logic              mode,
    input  logic              flush,
`ifdef SCR_BYPASS_EN
    input  logic              bypass,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] din,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] dout,
    output logic [LFSR_W-1:0] lfsr,
    output logic              locked
);

    // Number of words after which the register holds only received line bits.
    localparam int                LOCK_WORDS = (LFSR_W + DATA_W - 1) / DATA_W;
    localparam int                CNT_W      = $clog2(LOCK_WORDS + 1);
    localparam logic [CNT_W-1:0]  LOCK_CNT   = CNT_W'(LOCK_WORDS);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              prev_mode_q, prev_mode_d;

    logic              accept;
    logic              byp;
    logic [LFSR_W-1:0] lfsr_nx;
    logic [DATA_W-1:0] word_nx;
    logic [CNT_W-1:0]  cnt_base;

`ifdef SCR_BYPASS_EN
    assign byp = bypass;
`else
    assign byp = 1'b0;
`endif

    assign in_ready  = enable && !flush && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign lfsr      = lfsr_q;
    assign locked    = (cnt_q == LOCK_CNT);

    // Bit-serial scramble/descramble of the whole word, unrolled into one cycle.
    // The line bit (scrambled bit in scramble mode, received bit in descramble mode) feeds the register.
    always_comb begin
        logic fb;
        logic ob;
        lfsr_nx = lfsr_q;
        word_nx = '0;
        fb      = 1'b0;
        ob      = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            fb         = ^(lfsr_nx & TAPS);
            ob         = din[i] ^ fb;
            word_nx[i] = ob;
            lfsr_nx    = {lfsr_nx[LFSR_W-2:0], (mode ? din[i] : ob)};
        end
    end

    // A change of direction invalidates the history, so the lock count restarts before this word counts.
    always_comb begin
        cnt_base = (mode != prev_mode_q) ? '0 : cnt_q;
    end

    // Next-state: flush wins over accept and drain; bypassed words leave lfsr and lock state alone.
    always_comb begin
        lfsr_d      = lfsr_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        prev_mode_d = prev_mode_q;
        if (flush) begin
            lfsr_d      = SEED;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            if (byp) begin
                dout_d = din;
            end else begin
                dout_d      = word_nx;
                lfsr_d      = lfsr_nx;
                prev_mode_d = mode;
                cnt_d       = (cnt_base == LOCK_CNT) ? cnt_base : cnt_base + CNT_W'(1);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any pending output word.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lfsr_q      <= SEED;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            prev_mode_q <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            prev_mode_q <= prev_mode_d;
        end
    end

endmodule

// File: tb/tb_self_sync_scrambler_p.sv
// Bench for self_sync_scrambler_p: default parameters, a scrambler instance and a seeded descrambler.
// Expected values come from a bit-history reference model driven with the same stimulus.
// Backpressure is exercised with random out_ready, enable and flush.
module tb_self_sync_scrambler_p;

    localparam int          LW    = 7;
    localparam int          DW    = 8;
    localparam int          LOCK  = (LW + DW - 1) / DW;
    localparam logic [6:0]  TAPSV = 7'b1100000;

    logic       clock;
    logic       resetn;
    logic       enable, mode, flush, in_valid, out_ready;
    logic [7:0] din;
    logic       in_ready, out_valid, locked;
    logic [7:0] dout;
    logic [6:0] lfsr;

    logic       d2_in_valid;
    logic [7:0] d2_din;
    logic       d2_in_ready, d2_out_valid, d2_locked;
    logic [7:0] d2_dout;
    logic [6:0] d2_lfsr;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: h[id][k] = line bit delayed k+1 bit times.
    // id 0 mirrors dut, id 1 the descrambler, id 2 a source scrambler feeding it.
    bit         h [3][LW];
    bit         m_ov;
    logic [7:0] m_dout;
    int         m_cnt;
    bit         m_prev;

    self_sync_scrambler_p dut (
        .clock(clock), .resetn(resetn), .enable(enable), .mode(mode), .flush(flush),
`ifdef SCR_BYPASS_EN
        .bypass(1'b0),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
        .lfsr(lfsr), .locked(locked)
    );

    self_sync_scrambler_p #(.SEED(7'h7F)) dut2 (
        .clock(clock), .resetn(resetn), .enable(1'b1), .mode(1'b1), .flush(1'b0),
`ifdef SCR_BYPASS_EN
        .bypass(1'b0),
`endif
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .din(d2_din),
        .out_valid(d2_out_valid), .out_ready(1'b1), .dout(d2_dout),
        .lfsr(d2_lfsr), .locked(d2_locked)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [6:0] hist_vec(input int id);
        logic [6:0] v;
        for (int k = 0; k < LW; k++) v[k] = h[id][k];
        return v;
    endfunction

    task automatic hist_load(input int id, input logic [6:0] seed);
        for (int k = 0; k < LW; k++) h[id][k] = seed[k];
    endtask

    // One word through the model: per bit, feedback from tapped history, then push the line bit.
    task automatic ref_word(input int id, input logic [7:0] d, input bit desc, output logic [7:0] o);
        bit fb;
        o = '0;
        for (int b = 0; b < DW; b++) begin
            fb = 1'b0;
            for (int i = 0; i < LW; i++) if (TAPSV[i]) fb ^= h[id][i];
            o[b] = d[b] ^ fb;
            for (int k = LW - 1; k > 0; k--) h[id][k] = h[id][k-1];
            h[id][0] = desc ? d[b] : o[b];
        end
    endtask

    task automatic model_reset();
        hist_load(0, 7'h00);
        hist_load(1, 7'h7F);
        hist_load(2, 7'h00);
        m_ov = 0; m_dout = '0; m_cnt = 0; m_prev = 0;
    endtask

    // Drive one cycle of stimulus (called #1 after a rising edge), predict, then check after the edge.
    task automatic cyc(input bit v, input logic [7:0] d, input bit m, input bit e, input bit f, input bit r);
        bit         exp_rdy;
        logic [7:0] w;
        in_valid = v; din = d; mode = m; enable = e; flush = f; out_ready = r;
        #1;
        exp_rdy = e && !f && (!m_ov || r);
        chk("in_ready", in_ready, exp_rdy);
        if (f) begin
            hist_load(0, 7'h00);
            m_cnt = 0;
            m_ov  = 0;
        end else if (v && exp_rdy) begin
            ref_word(0, d, m, w);
            m_dout = w;
            m_ov   = 1;
            if (m != m_prev) m_cnt = 0;
            if (m_cnt < LOCK) m_cnt++;
            m_prev = m;
        end else if (m_ov && r) begin
            m_ov = 0;
        end
        @(posedge clock);
        #1;
        chk("out_valid", out_valid, m_ov);
        if (m_ov) chk("dout", dout, m_dout);
        chk("lfsr", lfsr, hist_vec(0));
        chk("locked", locked, (m_cnt >= LOCK));
    endtask

    initial begin
        logic [7:0] held, s, e2;
        bit         cur_mode;
        resetn = 0; enable = 0; mode = 0; flush = 0; in_valid = 0; out_ready = 0; din = '0;
        d2_in_valid = 0; d2_din = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_lfsr", lfsr, 7'h00);
        chk("rst_dout", dout, 8'h00);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_d2_lfsr", d2_lfsr, 7'h7F);
        resetn = 1;

        // Single 0x01 word from seed 0, accepted on the first edge out of reset.
        cyc(1, 8'h01, 0, 1, 0, 1);
        chk("c1_dout", dout, 8'hC1);

        // All-zero words from a zero register stay zero.
        cyc(0, 8'h00, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 8'h00, 0, 1, 0, 1);
            chk("zero_dout", dout, 8'h00);
            chk("zero_lfsr", lfsr, 7'h00);
        end

        // Stall the output for three cycles with input pending.
        cyc(1, 8'h3C, 0, 1, 0, 1);
        held = dout;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 8'($urandom), 0, 1, 0, 0);
            chk("hold_dout", dout, held);
        end
        cyc(1, 8'h77, 0, 1, 0, 1);
        cyc(0, 8'h00, 0, 1, 0, 1);

        // Five words, then flush together with a valid input.
        for (int i = 0; i < 5; i++) cyc(1, 8'($urandom), 0, 1, 0, 1);
        cyc(1, 8'($urandom), 0, 1, 1, 1);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_lfsr", lfsr, 7'h00);
        chk("flush_locked", locked, 1'b0);

        // Mode toggle mid-stream, then back.
        cyc(1, 8'h12, 0, 1, 0, 1);
        cyc(1, 8'h34, 1, 1, 0, 1);
        cyc(1, 8'h56, 1, 1, 0, 1);
        cyc(1, 8'h78, 0, 1, 0, 1);

        // Randomised traffic with backpressure, disable, flush and mode changes.
        cur_mode = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) cur_mode = ~cur_mode;
            cyc(($urandom_range(0, 3) != 0), 8'($urandom), cur_mode,
                ($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 3) != 0));
        end

        // Reset with a word pending discards it immediately.
        cyc(1, 8'hA5, 0, 1, 0, 0);
        resetn = 0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_lfsr", lfsr, 7'h00);
        chk("mid_rst_locked", locked, 1'b0);
        model_reset();
        #1;
        resetn = 1;
        in_valid = 0;
        @(posedge clock);
        #1;

        // Scrambled 0xAA stream into a descrambler seeded with all ones.
        for (int w = 0; w < 6; w++) begin
            ref_word(2, 8'hAA, 0, s);
            ref_word(1, s, 1, e2);
            d2_in_valid = 1;
            d2_din      = s;
            @(posedge clock);
            #1;
            chk("d2_out_valid", d2_out_valid, 1'b1);
            chk("d2_dout_model", d2_dout, e2);
            if (w >= 1) chk("d2_dout_aa", d2_dout, 8'hAA);
            chk("d2_locked", d2_locked, 1'b1);
            chk("d2_lfsr", d2_lfsr, hist_vec(1));
        end
        d2_in_valid = 0;
        @(posedge clock);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
